// File: rtl/cla_seq_pkg.sv
// Shared constants for the sequential carry-lookahead adder:
// FSM state encoding, slice width and add/subtract op encoding.
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_seq_adder_cla_unit.sv
// CLA_UNIT: 4-bit carry-lookahead slice.
// All four carries are formed directly from generate/propagate terms.
module CLA_UNIT (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  assign c_s[0] = c_in;
  assign c_s[1] = g_s[0] | (p_s[0] & c_s[0]);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

  assign s     = p_s ^ c_s[3:0];
  assign c_out = c_s[4];

endmodule

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: WIDTH-bit add/subtract that reuses one 4-bit CLA slice
// over WIDTH/4 cycles, with a start/ready/done handshake.
// Optional macro CLA_SEQ_EARLY_EXIT_EN: finish early once the remaining
// operand bits can only produce a constant fill.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             sign,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = $clog2(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_t             state_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic               c_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               op_sub_r;
  logic               a_msb_r;
  logic               beff_msb_r;
  logic [WIDTH-1:0]   result_r;
  logic               cout_r;
  logic               zero_r;
  logic               sign_r;
  logic               ovf_r;
  logic               ready_r;
  logic               done_r;

  logic [3:0]         slice_sum_s;
  logic               slice_c_s;
  logic [WIDTH-1:0]   res_next_s;
  logic [WIDTH-1:0]   a_next_s;
  logic [WIDTH-1:0]   b_next_s;
  logic [WIDTH-1:0]   final_s;
  logic               early_s;
  logic               exit_s;

  CLA_UNIT u_slice (
    .a     (a_sh_r[3:0]),
    .b     (b_sh_r[3:0]),
    .c_in  (c_r),
    .s     (slice_sum_s),
    .c_out (slice_c_s)
  );

  // New slice sum enters at the top; vacated B bits take the op's fill
  // value so the early-exit test can compare against a full-width constant.
  assign res_next_s = {slice_sum_s, result_r[WIDTH-1:SLICE_W]};
  assign a_next_s   = {4'b0000, a_sh_r[WIDTH-1:SLICE_W]};
  assign b_next_s   = {{SLICE_W{op_sub_r}}, b_sh_r[WIDTH-1:SLICE_W]};

`ifdef CLA_SEQ_EARLY_EXIT_EN
  logic [CNT_W-1:0]   rem_s;
  logic [CNT_W+1:0]   sh_s;

  // Detect a constant tail and align the partial result into its final place.
  always_comb begin
    rem_s   = LAST_CNT - cnt_r;
    sh_s    = {rem_s, 2'b00};
    early_s = (a_next_s == {WIDTH{1'b0}}) &&
              (b_next_s == {WIDTH{op_sub_r}}) && !slice_c_s;
    final_s = (res_next_s >> sh_s) |
              ({WIDTH{op_sub_r}} & ~({WIDTH{1'b1}} >> sh_s));
  end
`else
  // Fixed latency: the final result is simply the last shifted value.
  always_comb begin
    early_s = 1'b0;
    final_s = res_next_s;
  end
`endif

  assign exit_s = (cnt_r == LAST_CNT) || early_s;

  // Control FSM, operand/result shifters and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      a_sh_r     <= {WIDTH{1'b0}};
      b_sh_r     <= {WIDTH{1'b0}};
      c_r        <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      op_sub_r   <= 1'b0;
      a_msb_r    <= 1'b0;
      beff_msb_r <= 1'b0;
      result_r   <= {WIDTH{1'b0}};
      cout_r     <= 1'b0;
      zero_r     <= 1'b0;
      sign_r     <= 1'b0;
      ovf_r      <= 1'b0;
      ready_r    <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r     <= a;
            b_sh_r     <= (op_sub == OP_ADD) ? b : ~b;
            c_r        <= op_sub;
            cnt_r      <= {CNT_W{1'b0}};
            op_sub_r   <= op_sub;
            a_msb_r    <= a[WIDTH-1];
            beff_msb_r <= (op_sub == OP_ADD) ? b[WIDTH-1] : ~b[WIDTH-1];
            ready_r    <= 1'b0;
            state_r    <= ST_RUN;
          end else begin
            ready_r    <= 1'b1;
          end
        end
        ST_RUN: begin
          a_sh_r <= a_next_s;
          b_sh_r <= b_next_s;
          c_r    <= slice_c_s;
          cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (exit_s) begin
            result_r <= final_s;
            cout_r   <= slice_c_s;
            zero_r   <= (final_s == {WIDTH{1'b0}});
            sign_r   <= final_s[WIDTH-1];
            ovf_r    <= (a_msb_r == beff_msb_r) && (final_s[WIDTH-1] != a_msb_r);
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            result_r <= res_next_s;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign zero   = zero_r;
  assign sign   = sign_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=32): table-driven vectors,
// a queue scoreboard filled on acceptance and drained on done, and
// hand-written sequences for handshake, reset and back-to-back cases.
module tb_cla_seq_adder;

  localparam int WIDTH  = 32;
  localparam int NSLICE = WIDTH / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              op_sub;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              ready;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              cout;
  logic              zero;
  logic              sign;
  logic              ovf;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .sign   (sign),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             co;
    logic             z;
    logic             s;
    logic             o;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    exp_t             e;
  } vec_t;

  exp_t sb[$];
  exp_t exp_next;

  int compared   = 0;
  int mismatched = 0;
  int edge_cnt   = 0;
  int acc_edge   = 0;
  int prev_acc   = 0;
  int last_gap   = 0;
  int last_lat   = 0;
  int acc_cnt    = 0;
  int done_cnt   = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from 64-bit math.
  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sub);
    exp_t e;
    logic [WIDTH:0] s;
    longint sr;
    if (sub) begin
      e.r  = x - y;
      e.co = (x >= y);
      sr   = longint'($signed(x)) - longint'($signed(y));
    end else begin
      s    = {1'b0, x} + {1'b0, y};
      e.r  = s[WIDTH-1:0];
      e.co = s[WIDTH];
      sr   = longint'($signed(x)) + longint'($signed(y));
    end
    e.z = (e.r == 32'd0);
    e.s = e.r[WIDTH-1];
    e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return e;
  endfunction

  // Push expected result whenever the DUT accepts a start.
  always @(posedge clk) begin
    edge_cnt++;
    if (!rst && start && ready) begin
      sb.push_back(exp_next);
      last_gap = edge_cnt - prev_acc;
      prev_acc = edge_cnt;
      acc_edge = edge_cnt;
      acc_cnt++;
    end
  end

  // Compare on done; check pulse width and ready return one cycle later.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        check("done_width", done, 1'b0);
        check("ready_after_done", ready, 1'b1);
      end
      if (done) begin
        done_cnt++;
        check("ready_low_in_done", ready, 1'b0);
        if (sb.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          last_lat = edge_cnt - acc_edge;
          check("result", result, e.r);
          check("cout", cout, e.co);
          check("zero", zero, e.z);
          check("sign", sign, e.s);
          check("ovf", ovf, e.o);
`ifdef CLA_SEQ_EARLY_EXIT_EN
          check("latency_bound", last_lat <= NSLICE, 1'b1);
`else
          check("latency", last_lat, NSLICE);
`endif
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sub, input exp_t e);
    logic ok;
    @(negedge clk);
    a = x; b = y; op_sub = sub; exp_next = e; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", ok, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~x; b = x ^ y; op_sub = ~sub;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && ready) break;
    end
    check("idle_timeout", sb.size(), 0);
  endtask

  vec_t tbl[8];

  initial begin
    int base_a;
    int base_d;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic s;

    tbl[0] = '{32'h0000000F, 32'h00000001, 1'b0, '{32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{32'h00000005, 32'h00000007, 1'b1, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, '{32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[4] = '{32'h80000000, 32'h00000001, 1'b1, '{32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[5] = '{32'h00000000, 32'h00000000, 1'b1, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, '{32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1}};
    tbl[7] = '{32'h00000007, 32'h00000005, 1'b1, '{32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0}};

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    exp_next = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {cout, zero, sign, ovf}, 4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].e);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("result_hold", result, 32'h00000002);
    check("cout_hold", cout, 1'b1);

    for (int i = 0; i < 6; i++) begin
      x = $urandom; y = $urandom; s = 1'($urandom_range(1, 0));
      issue(x, y, s, model(x, y, s));
      wait_idle();
    end

    // Start held during RUN with different operands must be ignored.
    issue(32'h11111111, 32'h22222222, 1'b0, model(32'h11111111, 32'h22222222, 1'b0));
    for (int i = 0; i < 5; i++) begin
      x = $urandom; y = $urandom;
      a = x; b = y; op_sub = 1'b1; exp_next = model(x, y, 1'b1); start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Reset in the middle of RUN: no done, outputs back to reset values.
    issue(32'h0F0F0F0F, 32'h01010101, 1'b0, model(32'h0F0F0F0F, 32'h01010101, 1'b0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    check("midrst_ready", ready, 1'b1);
    check("midrst_result", result, 32'h0);
    check("midrst_done", done, 1'b0);
    check("midrst_flags", {cout, zero, sign, ovf}, 4'b0000);
    base_d = done_cnt;
    repeat (14) @(negedge clk);
    check("midrst_no_done", done_cnt - base_d, 0);

    // 3 + 4: shortened latency with early exit, full latency otherwise.
    issue(32'd3, 32'd4, 1'b0, model(32'd3, 32'd4, 1'b0));
    wait_idle();
`ifdef CLA_SEQ_EARLY_EXIT_EN
    check("early_exit_faster", last_lat < NSLICE, 1'b1);
`else
    check("latency_3p4", last_lat, NSLICE);
`endif

    // Back-to-back with start held high.
    @(negedge clk);
    base_a = acc_cnt; base_d = done_cnt;
    a = 32'h12345678; b = 32'h9ABCDEF0; op_sub = 1'b0;
    exp_next = model(32'h12345678, 32'h9ABCDEF0, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_cnt - base_a >= 3) break;
    end
    start = 1'b0;
    check("b2b_accepts", acc_cnt - base_a, 3);
    wait_idle();
    check("b2b_gap", last_gap, NSLICE + 2);
    check("b2b_done_count", done_cnt - base_d, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
